// File: rtl/axi_dma_write_engine_if.sv
// axi_dma_write_engine_if: AXI4 write-only port (AW, W, B channels) between the engine and memory.
interface axi_dma_write_engine_if #(
  parameter int ID_W = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
);
  logic [ADDR_W-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic awlock;
  logic [3:0] awqos;
  logic [ID_W-1:0] awid;
  logic awvalid;
  logic awready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic wlast;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic [ID_W-1:0] bid;
  logic bvalid;
  logic bready;
  modport master (
    output awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awqos, awid, awvalid,
    input awready,
    output wdata, wstrb, wlast, wvalid,
    input wready,
    input bresp, bid, bvalid,
    output bready
  );
  modport slave (
    input awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awqos, awid, awvalid,
    output awready,
    input wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bid, bvalid,
    input bready
  );
endinterface

// File: rtl/axi_dma_write_engine.sv
// axi_dma_write_engine: buffers a streamed payload and writes it out as 4 KB-safe AXI4 bursts.
module axi_dma_write_engine #(
  parameter int DMA_ADDR_WIDTH = 27,
  parameter int AXI_ID_WIDTH = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 512,
  parameter int BURST_LEN = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic rst,
  input logic write_req,
  input logic [DMA_ADDR_WIDTH-1:0] write_start_addr,
  input logic [DMA_ADDR_WIDTH-1:0] write_length,
  output logic write_busy,
  output logic write_done,
  output logic write_err,
  output logic din_rdy,
  input logic din_en,
  input logic [AXI_DATA_WIDTH-1:0] din,
  input logic din_eop,
  axi_dma_write_engine_if.master m_axi
);
  localparam int SZ = $clog2(AXI_DATA_WIDTH / 8);
  localparam int CW = DMA_ADDR_WIDTH + 1;
  localparam int FA = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int FC = $clog2(FIFO_DEPTH) + 1;
  localparam int QA = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OC = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = 12 - SZ;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [DMA_ADDR_WIDTH-1:0] in_left;
  logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FA-1:0] fwp, frp;
  logic [FC-1:0] fcnt, avail, ab;
  logic [7:0] q_len [MAX_OUTSTANDING];
  logic [QA-1:0] qwp, qrp;
  logic [OC-1:0] qcnt, outs, outs_n;
  logic [7:0] wcnt;
  logic [CW-1:0] rem, bnd, lim, beats;
  logic din_hs, aw_hs, w_hs, b_hs, issue, fin, accept;
  // avail counts buffered beats not yet claimed by an issued burst, so a burst never waits on input
  always_comb begin
    state_n = state == IDLE ? (write_req ? RUN : IDLE) : (fin ? IDLE : RUN);
    write_busy = state == RUN;
    accept = state == IDLE & write_req;
    din_rdy = write_busy & (in_left != '0) & (fcnt < FC'(FIFO_DEPTH));
    din_hs = din_en & din_rdy;
    aw_hs = m_axi.awvalid & m_axi.awready;
    w_hs = m_axi.wvalid & m_axi.wready;
    b_hs = m_axi.bvalid & m_axi.bready;
    ab = FC'(m_axi.awlen) + FC'(1);
    rem = CW'(in_left) + CW'(avail);
    bnd = CW'(1 << PW) - CW'(m_axi.awaddr[11:SZ]);
    lim = rem < bnd ? rem : bnd;
    beats = lim < CW'(BURST_LEN) ? lim : CW'(BURST_LEN);
    issue = write_busy & ~m_axi.awvalid & (beats != '0) & (CW'(avail) >= beats) & (outs < OC'(MAX_OUTSTANDING));
    outs_n = outs + OC'(aw_hs) - OC'(b_hs & (outs != '0));
    fin = write_busy & (rem == '0) & ~m_axi.awvalid & (qcnt == '0) & (outs_n == '0);
  end
  assign m_axi.awsize = 3'(SZ);
  assign m_axi.awburst = 2'b01;
  assign m_axi.awcache = 4'b0010;
  assign m_axi.awprot = '0;
  assign m_axi.awlock = 1'b0;
  assign m_axi.awqos = '0;
  assign m_axi.awid = '0;
  assign m_axi.wstrb = '1;
  assign m_axi.wvalid = qcnt != '0;
  assign m_axi.wdata = mem[frp];
  assign m_axi.wlast = m_axi.wvalid & (wcnt == q_len[qrp]);
  assign m_axi.bready = write_busy;
  always_ff @(posedge clk) begin
    if (din_hs) mem[fwp] <= din;
    if (aw_hs) q_len[qwp] <= m_axi.awlen;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      write_done <= 1'b0;
      write_err <= 1'b0;
      in_left <= '0;
      fwp <= '0;
      frp <= '0;
      fcnt <= '0;
      avail <= '0;
      qwp <= '0;
      qrp <= '0;
      qcnt <= '0;
      wcnt <= '0;
      outs <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.awaddr <= '0;
      m_axi.awlen <= '0;
    end else begin
      state <= state_n;
      write_done <= fin;
      outs <= outs_n;
      fcnt <= fcnt + FC'(din_hs) - FC'(w_hs);
      avail <= avail + FC'(din_hs) - (aw_hs ? ab : '0);
      qcnt <= qcnt + OC'(aw_hs) - OC'(w_hs & m_axi.wlast);
      if (accept) begin
        in_left <= write_length;
        write_err <= 1'b0;
        m_axi.awaddr <= AXI_ADDR_WIDTH'({write_start_addr, {SZ{1'b0}}});
      end else begin
        if (din_hs) in_left <= din_eop ? '0 : in_left - DMA_ADDR_WIDTH'(1);
        if (b_hs & (m_axi.bresp != 2'b00)) write_err <= 1'b1;
      end
      if (din_hs) fwp <= fwp == FA'(FIFO_DEPTH - 1) ? '0 : fwp + FA'(1);
      if (w_hs) begin
        frp <= frp == FA'(FIFO_DEPTH - 1) ? '0 : frp + FA'(1);
        wcnt <= m_axi.wlast ? '0 : wcnt + 8'd1;
        if (m_axi.wlast) qrp <= qrp == QA'(MAX_OUTSTANDING - 1) ? '0 : qrp + QA'(1);
      end
      if (issue) begin
        m_axi.awvalid <= 1'b1;
        m_axi.awlen <= 8'(beats - CW'(1));
      end else if (aw_hs) begin
        m_axi.awvalid <= 1'b0;
        m_axi.awaddr <= m_axi.awaddr + (AXI_ADDR_WIDTH'(ab) << SZ);
        qwp <= qwp == QA'(MAX_OUTSTANDING - 1) ? '0 : qwp + QA'(1);
      end
    end
  end
endmodule

// File: tb/tb_axi_dma_write_engine.sv
// tb_axi_dma_write_engine: directed transfers with a queue scoreboard checked by a separate AXI monitor.
module tb_axi_dma_write_engine;
  localparam int DW = 512;
  typedef struct packed {logic [31:0] addr; logic [7:0] len;} aw_t;
  typedef struct packed {logic [DW-1:0] data; logic last;} w_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic write_req = 1'b0;
  logic [26:0] write_start_addr = '0;
  logic [26:0] write_length = '0;
  logic write_busy, write_done, write_err, din_rdy;
  logic din_en = 1'b0;
  logic din_eop = 1'b0;
  logic [DW-1:0] din = '0;
  axi_dma_write_engine_if #(.ID_W(4), .ADDR_W(32), .DATA_W(DW)) m_axi ();
  axi_dma_write_engine #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .write_req(write_req), .write_start_addr(write_start_addr),
    .write_length(write_length), .write_busy(write_busy), .write_done(write_done),
    .write_err(write_err), .din_rdy(din_rdy), .din_en(din_en), .din(din), .din_eop(din_eop),
    .m_axi(m_axi)
  );
  always #5 clk = ~clk;
  aw_t aw_exp[$];
  w_t w_exp[$];
  logic [1:0] bresp_q[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, aw_cnt = 0, done_cnt = 0, done_cyc = 0, last_b_cyc = 0, acc_cnt = 0, pend = 0;
  bit hold = 1'b0;
  logic wl, bh, rs;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] pat(input int tid, input int i);
    return {16{8'(tid), 24'(i)}};
  endfunction
  task automatic plan(input int tid, input int n, input logic [31:0] a [8], input int l [8]);
    int beat = 0;
    for (int k = 0; k < n; k++) begin
      aw_exp.push_back({a[k], 8'(l[k] - 1)});
      for (int j = 0; j < l[k]; j++) begin
        w_exp.push_back({pat(tid, beat), j == l[k] - 1});
        beat++;
      end
    end
  endtask
  // Monitor: every handshake pops the scoreboard
  always @(negedge clk) if (!rst) begin
    if (m_axi.awvalid && m_axi.awready) begin
      aw_t e;
      aw_cnt++;
      check("aw_attr", {m_axi.awsize, m_axi.awburst, m_axi.awcache, &m_axi.wstrb}, {3'd6, 2'd1, 4'd2, 1'b1});
      check("aw_4k", 64'({20'd0, m_axi.awaddr[11:0]} + (32'(m_axi.awlen) + 1) * 64 <= 4096), 64'd1);
      if (aw_exp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL aw_unexpected: got addr %0h len %0d, none expected", m_axi.awaddr, m_axi.awlen);
      end else begin
        e = aw_exp.pop_front();
        check("aw_addr", m_axi.awaddr, e.addr);
        check("aw_len", m_axi.awlen, e.len);
      end
    end
    if (m_axi.wvalid && m_axi.wready) begin
      w_t e;
      if (w_exp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL w_unexpected: got data %0h, none expected", m_axi.wdata[63:0]);
      end else begin
        e = w_exp.pop_front();
        n_chk++;
        if (m_axi.wdata !== e.data || m_axi.wlast !== e.last) begin
          n_fail++;
          $display("FAIL w_beat: got data %0h last %0b expected data %0h last %0b",
                   m_axi.wdata[63:0], m_axi.wlast, e.data[63:0], e.last);
        end
      end
    end
    if (m_axi.bvalid && m_axi.bready) last_b_cyc = cyc;
    if (write_done) begin done_cnt++; done_cyc = cyc; end
  end
  // Memory side: AW/W always ready, one B per completed burst unless held
  initial begin
    m_axi.awready = 1'b1; m_axi.wready = 1'b1;
    m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00; m_axi.bid = '0;
    forever begin
      @(negedge clk);
      rs = rst;
      wl = m_axi.wvalid & m_axi.wready & m_axi.wlast & ~rst;
      bh = m_axi.bvalid & m_axi.bready;
      @(posedge clk); #1;
      if (rs) begin
        pend = 0; m_axi.bvalid = 1'b0;
      end else begin
        if (wl) pend++;
        if (bh) m_axi.bvalid = 1'b0;
        if (!m_axi.bvalid && pend > 0 && !hold) begin
          m_axi.bvalid = 1'b1; pend--;
          m_axi.bresp = bresp_q.size() > 0 ? bresp_q.pop_front() : 2'b00;
        end
      end
    end
  end
  task automatic req(input logic [26:0] a, input logic [26:0] n);
    @(posedge clk); #1;
    write_start_addr = a; write_length = n; write_req = 1'b1;
    @(posedge clk); #1;
    write_req = 1'b0;
  endtask
  task automatic send(input int tid, input int n, input int eop_at);
    int g = 0;
    logic acc;
    acc_cnt = 0;
    while (acc_cnt < n && g < 5000) begin
      din_en = 1'b1; din = pat(tid, acc_cnt); din_eop = acc_cnt == eop_at - 1;
      @(negedge clk); acc = din_rdy;
      @(posedge clk); #1;
      g++;
      if (acc) begin
        acc_cnt++;
        if (din_eop) break;
      end
    end
    din_en = 1'b0; din_eop = 1'b0;
    check("send_accepted", 64'(acc_cnt), 64'(eop_at > 0 ? eop_at : n));
  endtask
  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int g = 0;
    while (done_cnt == d0 && g < 3000) begin @(posedge clk); g++; end
    repeat (5) @(posedge clk);
    #1;
    check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_done_lat"}, 64'(done_cyc - last_b_cyc), 64'd1);
    check({name, "_aw_left"}, 64'(aw_exp.size()), 64'd0);
    check({name, "_w_left"}, 64'(w_exp.size()), 64'd0);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int a0, g, i;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {write_busy, write_done, write_err, din_rdy, m_axi.awvalid, m_axi.wvalid, m_axi.wlast}, 64'd0);
    check("reset_awaddr", {m_axi.awaddr, m_axi.awlen}, 64'd0);
    rst = 1'b0;
    // 1: 40 beats from 0 -> 16,16,8
    plan(1, 3, '{32'h0, 32'h400, 32'h800, 0, 0, 0, 0, 0}, '{16, 16, 8, 0, 0, 0, 0, 0});
    req(27'h0, 27'd40);
    send(1, 40, 0);
    wait_done("t1");
    // 2: 4 KB split
    plan(2, 2, '{32'hF80, 32'h1000, 0, 0, 0, 0, 0, 0}, '{2, 6, 0, 0, 0, 0, 0, 0});
    req(27'h3E, 27'd8);
    send(2, 8, 0);
    wait_done("t2");
    // 3: eop truncation at beat 20
    plan(3, 2, '{32'h4000, 32'h4400, 0, 0, 0, 0, 0, 0}, '{16, 4, 0, 0, 0, 0, 0, 0});
    req(27'h100, 27'd100);
    send(3, 100, 20);
    check("t3_rdy_after_eop", din_rdy, 1'b0);
    wait_done("t3");
    // 4: B withheld, outstanding limit and full FIFO
    plan(4, 8, '{32'h8000, 32'h8400, 32'h8800, 32'h8C00, 32'h9000, 32'h9400, 32'h9800, 32'h9C00},
         '{16, 16, 16, 16, 16, 16, 16, 16});
    hold = 1'b1;
    a0 = aw_cnt;
    req(27'h200, 27'd128);
    fork
      send(4, 128, 0);
      begin
        repeat (130) @(posedge clk);
        #1;
        check("t4_aw_issued", 64'(aw_cnt - a0), 64'd2);
        check("t4_awvalid_held", m_axi.awvalid, 1'b0);
        check("t4_rdy_full", din_rdy, 1'b0);
        check("t4_accepted", 64'(acc_cnt), 64'd96);
        hold = 1'b0;
      end
    join
    wait_done("t4");
    // 5: error response, held, then cleared by a zero-length request
    bresp_q.push_back(2'b00);
    bresp_q.push_back(2'b10);
    plan(5, 2, '{32'h1000, 32'h1400, 0, 0, 0, 0, 0, 0}, '{16, 16, 0, 0, 0, 0, 0, 0});
    req(27'h40, 27'd32);
    send(5, 32, 0);
    wait_done("t5");
    check("t5_err_set", write_err, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_err_held", write_err, 1'b1);
    a0 = aw_cnt;
    req(27'h10, 27'd0);
    check("t5_len0_busy", {write_busy, write_done, write_err}, 3'b100);
    @(posedge clk); #1;
    check("t5_len0_done", {write_busy, write_done}, 2'b01);
    @(posedge clk); #1;
    check("t5_len0_after", {write_busy, write_done}, 2'b00);
    check("t5_len0_no_aw", 64'(aw_cnt - a0), 64'd0);
    // 6: reset mid-burst, then a clean transfer
    plan(9, 4, '{32'h2000, 32'h2400, 32'h2800, 32'h2C00, 0, 0, 0, 0}, '{16, 16, 16, 16, 0, 0, 0, 0});
    req(27'h80, 27'd64);
    g = 0; i = 0;
    while (!m_axi.wvalid && g < 200) begin
      din_en = 1'b1; din = pat(9, i);
      @(negedge clk);
      if (din_rdy) i++;
      @(posedge clk); #1;
      g++;
    end
    check("t6_mid_burst", m_axi.wvalid, 1'b1);
    rst = 1'b1; din_en = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_outs", {write_busy, write_done, write_err, din_rdy, m_axi.awvalid, m_axi.wvalid, m_axi.wlast}, 64'd0);
    check("t6_rst_aw", {m_axi.awaddr, m_axi.awlen}, 64'd0);
    rst = 1'b0;
    aw_exp.delete(); w_exp.delete(); bresp_q.delete();
    repeat (2) @(posedge clk);
    plan(10, 1, '{32'h0, 0, 0, 0, 0, 0, 0, 0}, '{16, 0, 0, 0, 0, 0, 0, 0});
    req(27'h0, 27'd16);
    send(10, 16, 0);
    wait_done("t6");
    check("t6_err", write_err, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
